// File: rtl/id_pkg.sv
// id_pkg: character constants, emitter state encoding and the shared letter classifier
package id_pkg;
  localparam logic [7:0] CH_A_UP = 8'h41;
  localparam logic [7:0] CH_Z_UP = 8'h5A;
  localparam logic [7:0] CH_A_LO = 8'h61;
  localparam logic [7:0] CH_Z_LO = 8'h7A;
  localparam logic [7:0] CH_0    = 8'h30;
  localparam logic [7:0] CH_9    = 8'h39;
  localparam logic [7:0] CH_TERM = 8'h20;
  typedef enum logic [2:0] {IDLE, CONV, LETTER, DIGIT, TERM} state_t;
  function automatic logic is_letter(input logic [7:0] c);
    return (c >= CH_A_UP && c <= CH_Z_UP) || (c >= CH_A_LO && c <= CH_Z_LO);
  endfunction
endpackage

// File: rtl/bin2dec_seq.sv
// bin2dec_seq: repeated-subtraction binary to decimal converter, one step per cycle
module bin2dec_seq (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       go,
  input  logic [7:0] value,
  output logic [3:0] h,
  output logic [3:0] t,
  output logic [3:0] ones,
  output logic       rdy
);
  logic [7:0] rem_q, rem_d;
  logic [3:0] h_q, h_d, t_q, t_d, o_q, o_d;
  logic       run_q, run_d;
  // subtract hundreds first, then tens; the remainder below ten is the ones digit
  always_comb begin
    rem_d = rem_q;
    h_d   = h_q;
    t_d   = t_q;
    o_d   = o_q;
    run_d = run_q;
    if (go) begin
      rem_d = value;
      h_d   = '0;
      t_d   = '0;
      o_d   = '0;
      run_d = 1'b1;
    end else if (run_q) begin
      if (rem_q >= 8'd100) begin
        rem_d = rem_q - 8'd100;
        h_d   = h_q + 4'd1;
      end else if (rem_q >= 8'd10) begin
        rem_d = rem_q - 8'd10;
        t_d   = t_q + 4'd1;
      end else begin
        o_d   = rem_q[3:0];
        run_d = 1'b0;
      end
    end
  end
  // conversion state registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rem_q <= '0;
      h_q   <= '0;
      t_q   <= '0;
      o_q   <= '0;
      run_q <= 1'b0;
    end else begin
      rem_q <= rem_d;
      h_q   <= h_d;
      t_q   <= t_d;
      o_q   <= o_d;
      run_q <= run_d;
    end
  end
  assign h    = h_q;
  assign t    = t_q;
  assign ones = o_q;
  assign rdy  = ~run_q;
endmodule

// File: rtl/id_gen.sv
// id_gen: emits letter prefix, decimal number and space terminator one character per transfer
module id_gen
  import id_pkg::*;
#(
  parameter int MAX_LETTERS = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic [2:0]               prefix_len,
  input  logic [8*MAX_LETTERS-1:0] prefix,
  input  logic [7:0]               number,
  output logic [7:0]               char_out,
  output logic                     char_valid,
  input  logic                     char_ready,
  output logic                     busy,
  output logic                     done,
  output logic                     error
);
  state_t                   state_q, state_d;
  logic [2:0]               idx_q, idx_d, len_q, len_d, idx_n;
  logic [1:0]               dsel_q, dsel_d, first_sel, nsel;
  logic [8*MAX_LETTERS-1:0] pfx_q, pfx_d;
  logic [7:0]               char_q, char_d, letter_ch, digit_ch;
  logic                     valid_q, valid_d, busy_q, busy_d, done_q, done_d, err_q, err_d;
  logic                     go, legal, conv_rdy, xfer;
  logic [3:0]               h, t, ones, dval;

  bin2dec_seq u_conv (
    .clk   (clk),
    .rst_n (rst_n),
    .go    (go),
    .value (number),
    .h     (h),
    .t     (t),
    .ones  (ones),
    .rdy   (conv_rdy)
  );

  // a request is legal when its length is in range and every used character is a letter
  always_comb begin
    legal = prefix_len != 3'd0 && int'(prefix_len) <= MAX_LETTERS;
    for (int i = 0; i < MAX_LETTERS; i++)
      if (i < int'(prefix_len) && !is_letter(prefix[8*i +: 8])) legal = 1'b0;
  end

  assign xfer      = valid_q && char_ready;
  assign idx_n     = idx_q + 3'd1;
  assign letter_ch = pfx_q[8*idx_n +: 8];
  assign first_sel = h != 4'd0 ? 2'd0 : t != 4'd0 ? 2'd1 : 2'd2;
  assign nsel      = state_q == LETTER ? first_sel : dsel_q + 2'd1;
  assign dval      = nsel == 2'd0 ? h : nsel == 2'd1 ? t : ones;
  assign digit_ch  = CH_0 + {4'd0, dval};

  // emission FSM: next character is computed ahead so char_out only changes on transfer or state entry
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    len_d   = len_q;
    dsel_d  = dsel_q;
    pfx_d   = pfx_q;
    char_d  = char_q;
    valid_d = valid_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    go      = 1'b0;
    case (state_q)
      IDLE: if (start) begin
        pfx_d = prefix;
        len_d = prefix_len;
        if (legal) begin
          go      = 1'b1;
          busy_d  = 1'b1;
          state_d = CONV;
        end else err_d = 1'b1;
      end
      CONV: if (conv_rdy) begin
        state_d = LETTER;
        idx_d   = 3'd0;
        char_d  = pfx_q[7:0];
        valid_d = 1'b1;
      end
      LETTER: if (xfer) begin
        if (idx_q == len_q - 3'd1) begin
          state_d = DIGIT;
          dsel_d  = first_sel;
          char_d  = digit_ch;
        end else begin
          idx_d  = idx_n;
          char_d = letter_ch;
        end
      end
      DIGIT: if (xfer) begin
        if (dsel_q == 2'd2) begin
          state_d = TERM;
          char_d  = CH_TERM;
        end else begin
          dsel_d = nsel;
          char_d = digit_ch;
        end
      end
      TERM: if (xfer) begin
        state_d = IDLE;
        valid_d = 1'b0;
        busy_d  = 1'b0;
        done_d  = 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  // emitter registers; reset abandons any partial identifier
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      len_q   <= '0;
      dsel_q  <= '0;
      pfx_q   <= '0;
      char_q  <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      len_q   <= len_d;
      dsel_q  <= dsel_d;
      pfx_q   <= pfx_d;
      char_q  <= char_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign char_out   = char_q;
  assign char_valid = valid_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign error      = err_q;
endmodule

// File: tb/tb_id_gen.sv
// tb_id_gen: scoreboard bench for id_gen with a string-level reference model
module tb_id_gen;
  logic        clk = 0, rst_n = 0, start = 0, char_ready = 0;
  logic [2:0]  prefix_len = 0;
  logic [31:0] prefix = 0;
  logic [7:0]  number = 0;
  logic [7:0]  char_out;
  logic        char_valid, busy, done, error;
  int          checks = 0, errors = 0, done_cnt = 0;
  bit          rdy_force = 1;
  logic [7:0]  exp_q[$];

  id_gen #(.MAX_LETTERS(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .prefix_len (prefix_len),
    .prefix     (prefix),
    .number     (number),
    .char_out   (char_out),
    .char_valid (char_valid),
    .char_ready (char_ready),
    .busy       (busy),
    .done       (done),
    .error      (error)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", name, act, exp);
    end
  endtask

  // sink: ready either held high or randomly stalled
  initial forever begin
    @(posedge clk);
    #1;
    char_ready = rdy_force ? 1'b1 : ($urandom_range(0, 3) != 0);
  end

  // monitor: pops the scoreboard on every transfer and checks stall stability and done
  initial begin
    bit         stall, pend_done;
    logic [7:0] prev_ch, e;
    stall = 0;
    pend_done = 0;
    prev_ch = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        stall = 0;
        pend_done = 0;
      end else begin
        if (done) done_cnt++;
        if (pend_done) begin
          chk("done_pulse", int'(done), 1);
          chk("busy_drop", int'(busy), 0);
          pend_done = 0;
        end else if (done) begin
          errors++;
          $display("FAIL spurious_done got 1 expected 0");
        end
        if (stall) begin
          chk("stall_hold", int'(char_out), int'(prev_ch));
          chk("stall_valid", int'(char_valid), 1);
        end
        if (char_valid && char_ready) begin
          if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL extra_char got %0d expected none", char_out);
          end else begin
            e = exp_q.pop_front();
            chk("char", int'(char_out), int'(e));
            pend_done = (char_out == 8'h20);
          end
        end
        stall = char_valid && !char_ready;
        prev_ch = char_out;
      end
    end
  end

  task automatic push_exp(input logic [31:0] p, input int len, input int num);
    string s;
    for (int i = 0; i < len; i++) exp_q.push_back(p[8*i +: 8]);
    s = $sformatf("%0d", num);
    for (int i = 0; i < s.len(); i++) exp_q.push_back(s[i]);
    exp_q.push_back(8'h20);
  endtask

  task automatic req(input logic [31:0] p, input int len, input int num, input bit poke);
    int lat, n, dc0;
    dc0 = done_cnt;
    push_exp(p, len, num);
    prefix = p;
    prefix_len = 3'(len);
    number = 8'(num);
    start = 1;
    @(posedge clk);
    #1;
    start = 0;
    chk("busy_set", int'(busy), 1);
    lat = 0;
    while (!char_valid && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
    end
    chk("latency", lat, num / 100 + (num % 100) / 10 + 2);
    if (poke) begin
      prefix = 32'h5A5A5A5A;
      prefix_len = 3'd3;
      number = 8'd99;
      start = 1;
      repeat (2) begin
        @(posedge clk);
        #1;
      end
      start = 0;
    end
    n = 0;
    while (done_cnt == dc0 && n < 400) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (done_cnt == dc0) begin
      errors++;
      $display("FAIL done_timeout got none expected done");
    end
    chk("queue_drained", exp_q.size(), 0);
  endtask

  task automatic bad_req(input logic [31:0] p, input int len, input string name);
    prefix = p;
    prefix_len = 3'(len);
    number = 8'd42;
    start = 1;
    @(posedge clk);
    #1;
    start = 0;
    chk({name, "_error"}, int'(error), 1);
    chk({name, "_busy"}, int'(busy), 0);
    chk({name, "_valid"}, int'(char_valid), 0);
    @(posedge clk);
    #1;
    chk({name, "_error_drop"}, int'(error), 0);
    chk({name, "_idle"}, int'(busy) + int'(char_valid), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got timeout expected finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] p;
    int          n, len;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_char", int'(char_out), 0);
    chk("rst_valid", int'(char_valid), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_error", int'(error), 0);
    rst_n = 1;
    @(posedge clk);
    #1;
    req(32'h00006261, 2, 7, 1);
    repeat (3) @(posedge clk);
    #1;
    chk("ignored_start_valid", int'(char_valid), 0);
    chk("ignored_start_busy", int'(busy), 0);
    req(32'h00000058, 1, 255, 0);
    req(32'h00007A51, 2, 0, 0);
    req(32'h44434241, 4, 105, 0);
    req(32'h33336261, 2, 50, 0);
    bad_req(32'h00006261, 0, "len0");
    bad_req(32'h00003361, 2, "digit3");
    bad_req(32'h64636261, 5, "len5");
    rdy_force = 0;
    req(32'h44434241, 4, 100, 0);
    req(32'h00000061, 1, 10, 0);
    for (int k = 0; k < 30; k++) begin
      for (int i = 0; i < 4; i++) begin
        n = $urandom_range(0, 25);
        p[8*i +: 8] = $urandom_range(0, 1) != 0 ? 8'(8'h41 + n) : 8'(8'h61 + n);
      end
      len = $urandom_range(1, 4);
      req(p, len, $urandom_range(0, 255), 0);
    end
    rdy_force = 1;
    push_exp(32'h00006261, 2, 123);
    prefix = 32'h00006261;
    prefix_len = 3'd2;
    number = 8'd123;
    start = 1;
    @(posedge clk);
    #1;
    start = 0;
    n = 0;
    while (!(char_valid && char_out >= 8'h30 && char_out <= 8'h39) && n < 50) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (n >= 50) begin
      errors++;
      $display("FAIL reach_digit got timeout expected digit");
    end
    #2;
    rst_n = 0;
    #1;
    chk("midrst_char", int'(char_out), 0);
    chk("midrst_valid", int'(char_valid), 0);
    chk("midrst_busy", int'(busy), 0);
    chk("midrst_done", int'(done), 0);
    chk("midrst_error", int'(error), 0);
    exp_q.delete();
    @(posedge clk);
    #1;
    chk("midrst_hold", int'(char_valid) + int'(busy), 0);
    rst_n = 1;
    rdy_force = 0;
    req(32'h00004A69, 2, 208, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/id_gen.md
# id_gen

Sequential identifier generator: the transmit-side counterpart of the identifier recognizer FSM. On a start request it latches a letter prefix and an 8-bit number, converts the number to decimal by repeated subtraction, and emits the identifier one ASCII character per accepted transfer: letters, then decimal digits without leading zeros, then a space terminator. Its output stream drives the recognizer and the character-stream test benches.

## Interface
- MAX_LETTERS, 4: maximum prefix length; the prefix bus is 8*MAX_LETTERS bits wide.
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  request; sampled only while busy=0.
- prefix_len  in  3  number of prefix letters; legal range is 1..MAX_LETTERS.
- prefix  in  8*MAX_LETTERS  prefix characters; character i is at [8i+7:8i], and character 0 is emitted first.
- number  in  8  value to append in decimal (0..255).
- char  out  8  current ASCII character.
- char_valid  out  1  char is valid; held until accepted.
- char_ready  in  1  sink accepts char when char_valid && char_ready.
- busy  out  1  request in progress.
- done  out  1  one-cycle pulse after the terminator is accepted.
- error  out  1  one-cycle pulse when a request is rejected.

## Operation
- States: IDLE, CONV, LETTER, DIGIT, TERM.
- IDLE, start=1: latch prefix, prefix_len and number.
  - If prefix_len is 0 or greater than MAX_LETTERS, or any used prefix character is outside "A".."Z" / "a".."z": pulse error and stay in IDLE.
  - Otherwise go to CONV with busy=1.
- CONV: one step per cycle on rem (initialised to number), h and t (both 0).
  - If rem>=100: rem-=100, h++.
  - Else if rem>=10: rem-=10, t++.
  - Else: ones=rem, go to LETTER.
- LETTER: present prefix[idx] starting at idx=0. On each transfer idx++. After the transfer of index prefix_len-1, go to DIGIT.
- DIGIT: the digit sequence is h if h!=0; then t if h!=0 or t!=0; then ones, always emitted. Each char = "0"+digit. After the ones transfer, go to TERM.
- TERM: present 8'h20. On transfer go to IDLE, pulse done and drop busy in the same cycle.
- start while busy=1 is ignored. No queueing.
- Transfer rule: char and char_valid change only after a transfer or a state entry. char must never change while char_valid=1 and char_ready=0.
- Reset, including mid-stream: all state returns to IDLE immediately. A partial identifier is abandoned.
- Reset values: char=8'h00, char_valid=0, busy=0, done=0, error=0.

## Timing
- Start accepted at edge T: busy=1 after T. CONV occupies h+t+1 cycles. char_valid=1 with the first letter on the edge after the final CONV cycle.
  - number=0: first letter appears 2 edges after T.
  - number=255: first letter appears 9 edges after T.
- With char_ready held at 1: one character per cycle, no bubbles between LETTER, DIGIT and TERM.
- Total characters = prefix_len + number of digits + 1.
- done and busy=0 are visible the cycle after the terminator transfer. A new start is accepted in that same cycle.
- error pulses the cycle after the rejected start. busy stays 0.
- char_valid is registered. There is no combinational path from char_ready to char_valid or char.

## Structure
- Package id_pkg holds:
  - character constants: CH_A_UP, CH_Z_UP, CH_A_LO, CH_Z_LO, CH_0, CH_9, CH_TERM=8'h20;
  - the state encoding (3 bits);
  - the is_letter function, shared with the recognizer.
- One sub-module: bin2dec_seq, the repeated-subtraction converter.
  - Inputs: go, value[7:0].
  - Outputs: h, t, ones (4 bits each), rdy.
  - id_gen holds the handshake and emission FSM.

## Test plan
- prefix "ab", len=2, number=7, char_ready=1: stream "a","b","7",8'h20. done pulses one cycle after the 8'h20 transfer.
- prefix "X", number=255: first char_valid 9 edges after start. Stream "X","2","5","5"," ".
- number=0 and number=105: streams "…0 " and "…105 ". The zero tens digit is emitted; no leading zeros appear.
- char_ready toggled pseudo-randomly: char stays stable while stalled, with no lost or duplicated characters. Feeding the stream into the recognizer gives out=1 exactly after the first digit.
- prefix_len=0, and separately prefix containing "3": error pulses, busy stays 0, no char_valid. A start while busy is ignored.
- rst_n asserted during DIGIT: all outputs return to reset values asynchronously. A following start produces a complete, correct stream.
